// File: rtl/ihmac_pkg.sv
// rtl/ihmac_pkg.sv - shared states and constants for the HMAC-SHA1 padders
package ihmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        FILL,
        EMIT,
        PAD_EXTRA
    } state_t;

    localparam logic [7:0]  IPAD_BYTE_C    = 8'h36;
    localparam logic [7:0]  OPAD_BYTE_C    = 8'h5c;
    localparam int          SHA1_BLOCK_W   = 512;
    localparam int          SHA1_WORD_W    = 32;
    localparam int          SHA1_WORDS     = SHA1_BLOCK_W / SHA1_WORD_W;
    localparam int          OUTER_LEN_BITS = 672;
    localparam logic [31:0] PAD_WORD       = 32'h8000_0000;

    // Every key byte is XORed with the same pad byte.
    function automatic logic [SHA1_BLOCK_W-1:0] pad_key(
        input logic [SHA1_BLOCK_W-1:0] k,
        input logic [7:0]              b
    );
        return k ^ {(SHA1_BLOCK_W / 8){b}};
    endfunction

endpackage

// File: rtl/ihmac_last_word_pad.sv
// rtl/ihmac_last_word_pad.sv - masks the final message word and places the 0x80 marker
module ihmac_last_word_pad
    import ihmac_pkg::*;
(
    input  logic [SHA1_WORD_W-1:0] i_data,
    input  logic [1:0]             i_nbytes,
    output logic [SHA1_WORD_W-1:0] o_word,
    output logic                   o_spill
);

    // A fully populated last word has no room left, so the marker spills to the next slot.
    always_comb begin
        o_word  = '0;
        o_spill = 1'b0;
        case (i_nbytes)
            2'd0: o_word = {i_data[31:24], 8'h80, 16'h0000};
            2'd1: o_word = {i_data[31:16], 8'h80, 8'h00};
            2'd2: o_word = {i_data[31:8], 8'h80};
            default: begin
                o_word  = i_data;
                o_spill = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ihmac_inner_padder.sv
// rtl/ihmac_inner_padder.sv - inner key block and padded message blocks for HMAC-SHA1
module ihmac_inner_padder
    import ihmac_pkg::*;
#(
    parameter int         LEN_W     = 64,
    parameter logic [7:0] IPAD_BYTE = IPAD_BYTE_C
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SHA1_BLOCK_W-1:0] key,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SHA1_WORD_W-1:0]  s_data,
    input  logic                    s_last,
    input  logic [1:0]              s_nbytes,
    output logic [SHA1_BLOCK_W-1:0] blk_data,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic                    blk_first,
    output logic                    blk_last,
    output logic                    busy
);

    state_t                              r_state, w_state_nxt;
    logic [SHA1_WORDS-1:0][SHA1_WORD_W-1:0] r_blk, w_blk_nxt;
    logic [4:0]                          r_idx, w_idx_nxt;
    logic [LEN_W-1:0]                    r_len, w_len_nxt;
    logic                                r_first, w_first_nxt;
    logic                                r_last, w_last_nxt;
    logic                                r_extra, w_extra_nxt;
    logic                                r_pad80, w_pad80_nxt;

    logic [SHA1_WORD_W-1:0] w_pad_word;
    logic                   w_spill;
    logic [2:0]             w_k;
    logic [LEN_W-1:0]       w_len_last;
    logic [63:0]            w_len_last64;
    logic [63:0]            w_len64;
    logic [4:0]             w_pos;

    ihmac_last_word_pad u_last_word_pad (
        .i_data   (s_data),
        .i_nbytes (s_nbytes),
        .o_word   (w_pad_word),
        .o_spill  (w_spill)
    );

    assign w_k          = {1'b0, s_nbytes} + 3'd1;
    assign w_len_last   = r_len + LEN_W'({w_k, 3'b000});
    assign w_len_last64 = 64'(w_len_last);
    assign w_len64      = 64'(r_len);
    assign w_pos        = r_idx + {4'd0, w_spill};

    assign s_ready   = (r_state == FILL);
    assign blk_valid = (r_state == KEY) || (r_state == EMIT);
    assign blk_data  = r_blk;
    assign blk_first = r_first;
    assign blk_last  = r_last;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_blk_nxt   = r_blk;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_first_nxt = r_first;
        w_last_nxt  = r_last;
        w_extra_nxt = r_extra;
        w_pad80_nxt = r_pad80;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = KEY;
                    w_blk_nxt   = pad_key(key, IPAD_BYTE);
                    w_len_nxt   = LEN_W'(SHA1_BLOCK_W);
                    w_idx_nxt   = '0;
                    w_first_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_extra_nxt = 1'b0;
                    w_pad80_nxt = 1'b0;
                end
            end
            KEY: begin
                if (blk_ready) begin
                    w_state_nxt = FILL;
                    w_blk_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_first_nxt = 1'b0;
                end
            end
            FILL: begin
                if (s_valid && !s_last) begin
                    w_blk_nxt[r_idx[3:0]] = s_data;
                    w_idx_nxt = r_idx + 5'd1;
                    w_len_nxt = r_len + LEN_W'(SHA1_WORD_W);
                    if (r_idx == 5'd15) begin
                        w_state_nxt = EMIT;
                        w_last_nxt  = 1'b0;
                        w_extra_nxt = 1'b0;
                    end
                end else if (s_valid) begin
                    // Buffer was cleared on entry, so slots after the marker are already zero.
                    w_blk_nxt[r_idx[3:0]] = w_pad_word;
                    if (w_spill && (r_idx != 5'd15))
                        w_blk_nxt[r_idx[3:0] + 4'd1] = PAD_WORD;
                    w_idx_nxt   = r_idx + 5'd1;
                    w_len_nxt   = w_len_last;
                    w_state_nxt = EMIT;
                    if (w_pos <= 5'd13) begin
                        w_blk_nxt[14] = w_len_last64[63:32];
                        w_blk_nxt[15] = w_len_last64[31:0];
                        w_last_nxt    = 1'b1;
                        w_extra_nxt   = 1'b0;
                    end else begin
                        w_last_nxt  = 1'b0;
                        w_extra_nxt = 1'b1;
                        w_pad80_nxt = (w_pos == 5'd16);
                    end
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = 1'b0;
                    end else if (r_extra) begin
                        w_state_nxt = PAD_EXTRA;
                        w_extra_nxt = 1'b0;
                    end else begin
                        w_state_nxt = FILL;
                        w_blk_nxt   = '0;
                        w_idx_nxt   = '0;
                    end
                end
            end
            PAD_EXTRA: begin
                w_blk_nxt     = '0;
                w_blk_nxt[0]  = r_pad80 ? PAD_WORD : 32'h0;
                w_blk_nxt[14] = w_len64[63:32];
                w_blk_nxt[15] = w_len64[31:0];
                w_last_nxt    = 1'b1;
                w_pad80_nxt   = 1'b0;
                w_state_nxt   = EMIT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_blk   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_extra <= 1'b0;
            r_pad80 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_blk   <= w_blk_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
            r_extra <= w_extra_nxt;
            r_pad80 <= w_pad80_nxt;
        end
    end

endmodule

// File: tb/tb_ihmac_inner_padder.sv
// tb/tb_ihmac_inner_padder.sv - directed self-checking bench for ihmac_inner_padder
module tb_ihmac_inner_padder;

    typedef logic [15:0][31:0] blk_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [511:0] key = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic [1:0]   s_nbytes = '0;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         blk_first;
    logic         blk_last;
    logic         busy;

    int errors = 0;
    int checks = 0;
    blk_t e;

    always #5 clk = ~clk;

    ihmac_inner_padder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_nbytes  (s_nbytes),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [511:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] nb);
        int n = 0;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = l;
        s_nbytes = nb;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("s_ready_timeout", 512'(s_ready), 512'(1));
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_block(input string tag, input blk_t exp, input logic f,
                                input logic l, input int hold);
        int n = 0;
        while (!blk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_valid_timeout"}, 512'(blk_valid), 512'(1));
        chk({tag, "_data"}, blk_data, exp);
        chk({tag, "_first"}, 512'(blk_first), 512'(f));
        chk({tag, "_last"}, 512'(blk_last), 512'(l));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag, "_hold_valid"}, 512'(blk_valid), 512'(1));
            chk({tag, "_hold_data"}, blk_data, exp);
            chk({tag, "_hold_flags"}, 512'({blk_first, blk_last}), 512'({f, l}));
            chk({tag, "_hold_sready"}, 512'(s_ready), 512'(0));
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_flags", 512'({blk_valid, blk_first, blk_last, s_ready, busy}), 512'(0));
        chk("reset_data", blk_data, 512'(0));
        rst = 1'b0;

        // "abc" with all-zero key
        do_start('0);
        chk("t1_key_latency", 512'(blk_valid), 512'(1));
        chk("t1_busy", 512'(busy), 512'(1));
        e = '{default: 32'h36363636};
        expect_block("t1_key", e, 1'b1, 1'b0, 0);
        send_word(32'h61626300, 1'b1, 2'd2);
        chk("t1_blk_latency", 512'(blk_valid), 512'(1));
        e = '0; e[0] = 32'h61626380; e[15] = 32'h00000218;
        expect_block("t1_msg", e, 1'b0, 1'b1, 0);
        chk("t1_idle", 512'(busy), 512'(0));

        // 56 bytes with stalls on every block and input gaps
        do_start('0);
        e = '{default: 32'h36363636};
        expect_block("t2_key", e, 1'b1, 1'b0, 5);
        for (int i = 0; i < 14; i++) begin
            send_word(32'h1000_0000 + 32'(i), (i == 13), 2'd3);
            if (i % 2 == 1) repeat (2) @(negedge clk);
        end
        e = '0;
        for (int i = 0; i < 14; i++) e[i] = 32'h1000_0000 + 32'(i);
        e[14] = 32'h80000000;
        expect_block("t2_b1", e, 1'b0, 1'b0, 5);
        e = '0; e[15] = 32'h000003C0;
        expect_block("t2_b2", e, 1'b0, 1'b1, 5);
        chk("t2_idle", 512'(busy), 512'(0));

        // 64 bytes, marker spills into an extra block; start while busy is ignored
        do_start({16{32'h36363636}});
        e = '0;
        expect_block("t3_key", e, 1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) send_word(32'hA000_0000 + 32'(i), (i == 15), 2'd3);
        chk("t3_full_latency", 512'(blk_valid), 512'(1));
        do_start({512{1'b1}});
        for (int i = 0; i < 16; i++) e[i] = 32'hA000_0000 + 32'(i);
        expect_block("t3_b1", e, 1'b0, 1'b0, 3);
        e = '0; e[0] = 32'h80000000; e[15] = 32'h00000400;
        expect_block("t3_b2", e, 1'b0, 1'b1, 0);

        // 14 words, last holds 2 bytes: marker lands in word 13, single block
        do_start('0);
        e = '{default: 32'h36363636};
        expect_block("t4_key", e, 1'b1, 1'b0, 0);
        for (int i = 0; i < 14; i++) send_word(32'h2000_0000 + 32'(i), (i == 13), 2'd1);
        e = '0;
        for (int i = 0; i < 13; i++) e[i] = 32'h2000_0000 + 32'(i);
        e[13] = 32'h20008000; e[15] = 32'h000003B0;
        expect_block("t4_msg", e, 1'b0, 1'b1, 0);

        // reset mid-fill discards everything
        do_start('0);
        e = '{default: 32'h36363636};
        expect_block("t5_key", e, 1'b1, 1'b0, 0);
        send_word(32'hCAFEBABE, 1'b0, 2'd0);
        send_word(32'h12345678, 1'b0, 2'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_flags", 512'({blk_valid, busy, s_ready}), 512'(0));
        chk("t5_rst_data", blk_data, 512'(0));

        // 0x5c key, two-word message ending on a full word
        do_start({64{8'h5c}});
        e = '{default: 32'h6a6a6a6a};
        expect_block("t6_key", e, 1'b1, 1'b0, 0);
        send_word(32'h11223344, 1'b0, 2'd0);
        send_word(32'h55667788, 1'b1, 2'd3);
        e = '0; e[0] = 32'h11223344; e[1] = 32'h55667788; e[2] = 32'h80000000;
        e[15] = 32'h00000240;
        expect_block("t6_msg", e, 1'b0, 1'b1, 0);

        // single byte message
        do_start('0);
        e = '{default: 32'h36363636};
        expect_block("t7_key", e, 1'b1, 1'b0, 0);
        send_word(32'hDEADBEEF, 1'b1, 2'd0);
        e = '0; e[0] = 32'hDE800000; e[15] = 32'h00000208;
        expect_block("t7_msg", e, 1'b0, 1'b1, 0);
        chk("t7_idle", 512'(busy), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ihmac_inner_padder.md
Name: ihmac_inner_padder

Overview:
- Inner-hash front end of the HMAC-SHA1 datapath.
- Latches the 512-bit key on start and emits the inner key block (key XOR 0x36 per byte) to the SHA-1 core.
- Then packs a byte stream of 32-bit words into 512-bit message blocks and applies SHA-1 padding with inner-hash length (512 + 8·bytes).
- Sits upstream of the SHA-1 core; the core's 160-bit inner digest then goes to the outer padder.

Parameters:
- LEN_W, 64, width of the bit-length counter and of the length field in the final block.
- IPAD_BYTE, 8'h36, inner pad constant XORed into every key byte.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches key and begins a message; ignored unless IDLE
- key  in  512  HMAC key; word i = key[32i+31:32i]
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid && s_ready
- s_data  in  32  message word, big-endian (first byte in [31:24])
- s_last  in  1  marks final word of the message
- s_nbytes  in  2  valid bytes on the last word minus 1 (0→1 byte … 3→4 bytes); ignored when s_last=0
- blk_data  out  512  block to SHA-1 core; word j at [32j+31:32j]
- blk_valid  out  1  block valid; held until accepted
- blk_ready  in  1  core accepts block when blk_valid && blk_ready
- blk_first  out  1  qualifies blk_valid: this is the key block (core must restart its chaining state)
- blk_last  out  1  qualifies blk_valid: final padded block of the inner hash
- busy  out  1  high from accepted start until the last block handshakes

Behaviour:
- Reset (sync, rst=1): state IDLE; blk_valid, blk_first, blk_last, s_ready, busy = 0; blk_data, word buffer, word index, and length counter = 0. Reset mid-message discards all partial data with no flush.
- IDLE → KEY on start. Key words are latched XOR {4{IPAD_BYTE}}. Length counter is loaded with 512. blk_valid and blk_first rise the next cycle.
- KEY: hold the key block until handshake, then go to FILL with word index 0 and the buffer cleared.
- FILL: s_ready = 1 only while blk_valid = 0.
  - Each accepted non-last word is written at the current index; index++ and length += 32.
  - When index reaches 16, go to EMIT (blk_first = 0, blk_last = 0).
  - On an accepted last word with k = s_nbytes+1:
    - Bytes beyond k are masked to 0 and length += 8k.
    - If k < 4, byte k of that word = 0x80. If k = 4, the next word slot = 0x80000000.
    - Let w be the index of the word containing 0x80.
    - w ≤ 13: words w+1..13 = 0, words 14..15 = length (word 14 = high 32 bits, word 15 = low). Go to EMIT with blk_last = 1.
    - 14 ≤ w ≤ 15: words after w = 0. Go to EMIT with blk_last = 0, then PAD_EXTRA.
    - w = 16 (k = 4 on index 15): emit the full block, then PAD_EXTRA with word 0 = 0x80000000.
  - EMIT: hold the block until handshake. Then return to FILL (clear buffer, index 0), go to PAD_EXTRA, or go to IDLE if blk_last.
- PAD_EXTRA: words 0..13 zero (except 0x80000000 at word 0 in the w = 16 case); words 14..15 = length; blk_last = 1; to EMIT.
- blk_data, blk_first, and blk_last are stable while blk_valid && !blk_ready.
- Latency: the key block is valid 1 cycle after start. A full block is valid 1 cycle after its 16th word is accepted.
- start while not IDLE is ignored. Zero-length messages are unsupported; at least one word with s_last is required.
- The length counter wraps modulo 2^LEN_W with no error flag.

Decomposition:
- Package ihmac_pkg holds:
  - state enum {IDLE, KEY, FILL, EMIT, PAD_EXTRA}
  - IPAD/OPAD byte constants
  - SHA1_BLOCK_W = 512, SHA1_WORD_W = 32
  - OUTER_LEN_BITS = 672
- One sub-module, ihmac_last_word_pad, is combinational: given s_data and s_nbytes it returns the masked word, the 0x80 placement, and a spill flag.

Test Plan:
- Key all-zero, message "abc" (one word 0x61626300, s_last, s_nbytes = 2) → key block all words 0x36363636 with blk_first; then one block with word0 = 0x61626380, words 1–14 = 0, word15 = 0x00000218, blk_last.
- 14 full words (56 bytes) → block 1 has word14 = 0x80000000, word15 = 0, blk_last = 0; block 2 has words 0–13 = 0, word15 = 0x000003C0, blk_last = 1.
- 16 full words (64 bytes) → full data block with blk_last = 0; then word0 = 0x80000000, word15 = 0x00000400, blk_last = 1.
- Hold blk_ready low for 5 cycles on each block → blk_data/flags stable, s_ready = 0, no words lost; s_valid gaps inside FILL are tolerated.
- start pulsed while busy → ignored, output unchanged. Assert rst during FILL → next cycle blk_valid = 0, busy = 0; a subsequent start yields a clean key block.
- Key = 0x5c repeated, 2-word message ending with s_nbytes = 3 → word1 = data, word2 = 0x80000000, word15 = 0x00000240.
